// File: rtl/simon_pkg.sv
// Shared types and widths for the Simon Says datapath blocks
// (sequencer, pattern memory, blinker, input block).
package simon_pkg;

  localparam int ADDR_W = 4;
  localparam int NUM_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPEND,
    ST_PLAY,
    ST_WAIT_PB,
    ST_WAIT_IN,
    ST_CHECK,
    ST_WIN,
    ST_LOSE
  } game_state_t;

endpackage

// File: rtl/timeout_timer.sv
// Saturating per-entry timer; expired is raised once the count has reached
// TIMEOUT_CYC-1 while enabled.
module timeout_timer #(
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0]  LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/game_sequencer.sv
// Simon Says round controller: grows the pattern one symbol per round,
// triggers playback, then walks the pattern while checking player entries.
module game_sequencer
  import simon_pkg::*;
#(
  parameter int MAX_LEVEL   = 16,
  parameter int TIMEOUT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_W-1:0]  rand_num,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [NUM_W-1:0]  mem_wdata,
  input  logic [NUM_W-1:0]  mem_rdata,
  output logic              play_start,
  output logic [ADDR_W:0]   play_len,
  input  logic [ADDR_W-1:0] play_addr,
  input  logic              play_done,
  input  logic              in_valid,
  input  logic [NUM_W-1:0]  in_num,
  output logic [ADDR_W-1:0] level,
  output logic              busy,
  output logic              win,
  output logic              lose
);

  localparam logic [ADDR_W-1:0] LAST_LEVEL = ADDR_W'(MAX_LEVEL - 1);

  game_state_t       state_q;
  logic [ADDR_W-1:0] level_q;
  logic [ADDR_W-1:0] idx_q;
  logic [NUM_W-1:0]  entry_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [NUM_W-1:0]  mem_wdata_q;
  logic              play_start_q;
  logic [ADDR_W:0]   play_len_q;
  logic              expired;

  // Timer runs only while waiting for an entry, so it is fresh on every entry.
  timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != ST_WAIT_IN),
    .enable  (state_q == ST_WAIT_IN),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      idx_q        <= '0;
      entry_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      play_start_q <= 1'b0;
      play_len_q   <= 5'd1;
    end else begin
      mem_we_q     <= 1'b0;
      play_start_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (start) begin
            level_q     <= '0;
            idx_q       <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= rand_num;
            state_q     <= ST_APPEND;
          end
        end
        ST_APPEND: begin
          play_start_q <= 1'b1;
          play_len_q   <= {1'b0, level_q} + 5'd1;
          state_q      <= ST_PLAY;
        end
        ST_PLAY: state_q <= ST_WAIT_PB;
        ST_WAIT_PB: begin
          if (play_done) begin
            idx_q      <= '0;
            mem_addr_q <= '0;
            state_q    <= ST_WAIT_IN;
          end
        end
        ST_WAIT_IN: begin
          if (in_valid) begin
            entry_q <= in_num;
            state_q <= ST_CHECK;
          end else if (expired) begin
            state_q <= ST_LOSE;
          end
        end
        ST_CHECK: begin
          // mem_addr has held idx since WAIT_IN entry, so mem_rdata is idx's symbol.
          if (entry_q != mem_rdata) begin
            state_q <= ST_LOSE;
          end else if (idx_q != level_q) begin
            idx_q      <= idx_q + 4'd1;
            mem_addr_q <= idx_q + 4'd1;
            state_q    <= ST_WAIT_IN;
          end else if (level_q == LAST_LEVEL) begin
            state_q <= ST_WIN;
          end else begin
            level_q     <= level_q + 4'd1;
            mem_addr_q  <= level_q + 4'd1;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= rand_num;
            state_q     <= ST_APPEND;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr   = (state_q == ST_WAIT_PB) ? play_addr : mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign play_start = play_start_q;
  assign play_len   = play_len_q;
  assign level      = level_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_WIN) && (state_q != ST_LOSE);
  assign win        = (state_q == ST_WIN);
  assign lose       = (state_q == ST_LOSE);

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with a round-level reference model
// checked every cycle, plus literal spot checks along the scenario.
module tb_game_sequencer;

  localparam int MAXL = 4;
  localparam int TO   = 8;

  localparam int P_IDLE = 0, P_APPEND = 1, P_PLAY = 2, P_WAIT_PB = 3,
                 P_WAIT_IN = 4, P_CHECK = 5, P_WIN = 6, P_LOSE = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] rand_num = 2'd0;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata = 2'd0;
  logic       play_start;
  logic [4:0] play_len;
  logic [3:0] play_addr = 4'd0;
  logic       play_done = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_num = 2'd0;
  logic [3:0] level;
  logic       busy, win, lose;

  int total = 0;
  int bad   = 0;
  int tp[16];

  game_sequencer #(.MAX_LEVEL(MAXL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .rand_num(rand_num),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .play_start(play_start), .play_len(play_len), .play_addr(play_addr), .play_done(play_done),
    .in_valid(in_valid), .in_num(in_num), .level(level), .busy(busy), .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  // Pattern memory with synchronous read.
  logic [1:0] mem [16];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game rules applied to plain integers.
  int m_phase = P_IDLE, m_level = 0, m_idx = 0, m_cap = 0, m_tc = 0, m_wdata = 0, m_len = 1;
  int pat[16];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = P_IDLE; m_level = 0; m_idx = 0; m_tc = 0; m_wdata = 0; m_len = 1;
    end else begin
      case (m_phase)
        P_IDLE, P_WIN, P_LOSE:
          if (start) begin m_level = 0; m_idx = 0; m_wdata = int'(rand_num); m_phase = P_APPEND; end
        P_APPEND: begin pat[m_level] = m_wdata; m_len = m_level + 1; m_phase = P_PLAY; end
        P_PLAY: m_phase = P_WAIT_PB;
        P_WAIT_PB: if (play_done) begin m_idx = 0; m_tc = 0; m_phase = P_WAIT_IN; end
        P_WAIT_IN:
          if (in_valid) begin m_cap = int'(in_num); m_phase = P_CHECK; end
          else if (m_tc == TO - 1) m_phase = P_LOSE;
          else m_tc++;
        P_CHECK:
          if (m_cap != pat[m_idx]) m_phase = P_LOSE;
          else if (m_idx < m_level) begin m_idx++; m_tc = 0; m_phase = P_WAIT_IN; end
          else if (m_level == MAXL - 1) m_phase = P_WIN;
          else begin m_level++; m_wdata = int'(rand_num); m_phase = P_APPEND; end
        default: m_phase = P_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(!(m_phase == P_IDLE || m_phase == P_WIN || m_phase == P_LOSE)));
    chk("win", int'(win), int'(m_phase == P_WIN));
    chk("lose", int'(lose), int'(m_phase == P_LOSE));
    chk("level", int'(level), m_level);
    chk("mem_we", int'(mem_we), int'(m_phase == P_APPEND));
    chk("play_start", int'(play_start), int'(m_phase == P_PLAY));
    if (reset) begin
      chk("rst_mem_addr", int'(mem_addr), 0);
      chk("rst_mem_wdata", int'(mem_wdata), 0);
      chk("rst_play_len", int'(play_len), 1);
    end else begin
      if (m_phase == P_APPEND) begin
        chk("append_addr", int'(mem_addr), m_level);
        chk("append_wdata", int'(mem_wdata), m_wdata);
      end
      if (m_phase == P_PLAY) chk("play_len", int'(play_len), m_len);
      if (m_phase == P_WAIT_PB) chk("pb_addr", int'(mem_addr), int'(play_addr));
      if (m_phase == P_WAIT_IN) chk("in_addr", int'(mem_addr), m_idx);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_start(input int r);
    rand_num = 2'(r); start = 1'b1; cyc(1); start = 1'b0;
  endtask

  task automatic enter(input int s);
    in_valid = 1'b1; in_num = 2'(s); cyc(1); in_valid = 1'b0; cyc(1);
  endtask

  // Called in APPEND; plays round lvl with correct entries from tp[].
  task automatic round(input int lvl);
    cyc(1);
    rand_num = 2'(tp[lvl+1]);
    cyc(1);
    play_addr = 4'(lvl + 5);
    in_valid = 1'b1; in_num = 2'(~tp[0]);
    cyc(1);
    in_valid = 1'b0;
    play_done = 1'b1; cyc(1); play_done = 1'b0;
    for (int i = 0; i <= lvl; i++) enter(tp[i]);
  endtask

  initial begin
    #1 reset = 1'b1;
    cyc(2);
    chk("lit_rst_level", int'(level), 0);
    chk("lit_rst_len", int'(play_len), 1);
    reset = 1'b0;
    cyc(1);

    // Round 0 stores 2, correct entry, round 1 stores 1, then wrong entry.
    do_start(2);
    chk("lit_t1_we", int'(mem_we), 1);
    chk("lit_t1_addr", int'(mem_addr), 0);
    chk("lit_t1_wdata", int'(mem_wdata), 2);
    cyc(1);
    chk("lit_t1_ps", int'(play_start), 1);
    chk("lit_t1_len", int'(play_len), 1);
    cyc(1);
    play_addr = 4'd7; #1;
    chk("lit_t1_pbaddr", int'(mem_addr), 7);
    play_done = 1'b1; cyc(1); play_done = 1'b0;
    rand_num = 2'd1;
    enter(2);
    chk("lit_t1_lvl1", int'(level), 1);
    chk("lit_t1_we1", int'(mem_we), 1);
    chk("lit_t1_addr1", int'(mem_addr), 1);
    chk("lit_t1_wdata1", int'(mem_wdata), 1);
    cyc(1);
    chk("lit_t1_len2", int'(play_len), 2);
    cyc(1);
    play_done = 1'b1; cyc(1); play_done = 1'b0;
    enter(2);
    in_valid = 1'b1; in_num = 2'd3; cyc(1); in_valid = 1'b0;
    chk("lit_t1_check", int'(lose), 0);
    cyc(1);
    chk("lit_t1_lose", int'(lose), 1);
    chk("lit_t1_lose_lvl", int'(level), 1);

    // Timeout: eight idle WAIT_IN cycles lose the game.
    do_start(0);
    cyc(2);
    play_done = 1'b1; cyc(1); play_done = 1'b0;
    cyc(7);
    chk("lit_t2_still", int'(lose), 0);
    cyc(1);
    chk("lit_t2_lose", int'(lose), 1);

    // Entry on the expiry cycle wins over the timeout; game continues to level 3.
    tp[0] = 3; tp[1] = 1; tp[2] = 2; tp[3] = 0; tp[4] = 3;
    do_start(3);
    cyc(2);
    play_done = 1'b1; cyc(1); play_done = 1'b0;
    cyc(7);
    rand_num = 2'(tp[1]);
    in_valid = 1'b1; in_num = 2'd3; cyc(1); in_valid = 1'b0;
    chk("lit_t3_check_busy", int'(busy), 1);
    chk("lit_t3_check_lose", int'(lose), 0);
    cyc(1);
    chk("lit_t3_append", int'(mem_we), 1);
    chk("lit_t3_lvl", int'(level), 1);
    round(1);
    round(2);
    cyc(2);
    play_done = 1'b1; cyc(1); play_done = 1'b0;
    enter(tp[0]);
    chk("lit_t4_lvl3", int'(level), 3);

    // Asynchronous reset mid-WAIT_IN, then a fresh start writes address 0.
    #1 reset = 1'b1; #1;
    chk("lit_t4_rst_lvl", int'(level), 0);
    chk("lit_t4_rst_busy", int'(busy), 0);
    chk("lit_t4_rst_addr", int'(mem_addr), 0);
    chk("lit_t4_rst_len", int'(play_len), 1);
    @(posedge clk); #2 reset = 1'b0;
    cyc(1);
    tp[0] = 1; tp[1] = 2; tp[2] = 3; tp[3] = 1; tp[4] = 0;
    do_start(1);
    chk("lit_t4_we", int'(mem_we), 1);
    chk("lit_t4_addr", int'(mem_addr), 0);
    chk("lit_t4_wdata", int'(mem_wdata), 1);

    // Full game to MAX_LEVEL, then restart from WIN.
    for (int l = 0; l < MAXL; l++) round(l);
    chk("lit_t5_win", int'(win), 1);
    chk("lit_t5_lvl", int'(level), 3);
    chk("lit_t5_busy", int'(busy), 0);
    cyc(2);
    chk("lit_t5_hold", int'(level), 3);
    do_start(2);
    chk("lit_t5_restart_lvl", int'(level), 0);
    chk("lit_t5_restart_addr", int'(mem_addr), 0);
    chk("lit_t5_restart_we", int'(mem_we), 1);
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
